// File: rtl/wb_sdram_port_pkg.sv
// Shared definitions for the Wishbone-to-SDRAM-controller port: FSM states
// and the derivation of the line geometry from the controller burst length.
package wb_sdram_port_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_HI   = 3'd1,
    WR_LO   = 3'd2,
    RD_REQ  = 3'd3,
    RD_FILL = 3'd4
  } state_e;

  // The controller only supports bursts of 4 or 8 halfwords.
  function automatic bit burst_len_ok(input int bl);
    return (bl == 4) || (bl == 8);
  endfunction

  // Byte-offset width of one line of BURST_LENGTH halfwords.
  function automatic int line_bits(input int bl);
    return $clog2(bl * 2);
  endfunction

endpackage

// File: rtl/wb_sdram_port_linebuf.sv
// One-line read buffer: BURST_LENGTH halfwords, the line tag and a valid flag.
// Reads return a big-endian 32-bit word selected by word index.
module wb_sdram_port_linebuf #(
  parameter int BURST_LENGTH = 8,
  parameter int LINE_BITS    = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   wr_en_i,
  input  logic [LINE_BITS-2:0]   wr_idx_i,
  input  logic [15:0]            wr_dat_i,
  input  logic [LINE_BITS-3:0]   rd_widx_i,
  output logic [31:0]            rd_dat_o,
  input  logic                   tag_load_i,
  input  logic [31-LINE_BITS:0]  tag_i,
  output logic [31-LINE_BITS:0]  tag_o,
  input  logic                   clear_i,
  input  logic                   set_valid_i,
  output logic                   valid_o
);

  logic [15:0]           mem_q [BURST_LENGTH];
  logic [31-LINE_BITS:0] tag_q;
  logic                  valid_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_idx_i] <= wr_dat_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      if (tag_load_i) tag_q <= tag_i;
      // A clear comes from a new bus access and always beats a late set.
      if (clear_i)          valid_q <= 1'b0;
      else if (set_valid_i) valid_q <= 1'b1;
    end
  end

  assign rd_dat_o = {mem_q[{rd_widx_i, 1'b0}], mem_q[{rd_widx_i, 1'b1}]};
  assign tag_o    = tag_q;
  assign valid_o  = valid_q;

endmodule

// File: rtl/wb_sdram_port.sv
// Wishbone B3 classic slave that splits 32-bit writes into halfword requests
// and serves reads from a one-line buffer filled by controller read bursts.
module wb_sdram_port
  import wb_sdram_port_pkg::*;
#(
  parameter int BURST_LENGTH = 8
) (
  input  logic        sdram_clk,
  input  logic        sdram_rst_n,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        ctrl_acc_o,
  output logic [31:0] ctrl_adr_o,
  output logic [15:0] ctrl_dat_o,
  output logic [1:0]  ctrl_sel_o,
  output logic        ctrl_we_o,
  input  logic        ctrl_ack_i,
  input  logic [31:0] ctrl_adr_i,
  input  logic [15:0] ctrl_dat_i,
  output logic [2:0]  state_o,
  output logic        line_valid_o
);

  localparam int LINE_BITS = line_bits(BURST_LENGTH);
  localparam int CNT_W     = LINE_BITS - 1;

  // Handshakes: a bus request is taken when cyc & stb are high and no ack is
  // pending; the master holds it until wb_ack_o. A controller request stands
  // while ctrl_acc_o is high and is consumed in the cycle ctrl_ack_i is high.
  state_e                state_q, state_d;
  logic                  acc_q, acc_d, we_q, we_d, ack_q, ack_d;
  logic [31:0]           adr_q, adr_d, rdat_q, rdat_d;
  logic [15:0]           dat_q, dat_d, beat0_q, beat0_d;
  logic [1:0]            sel_q, sel_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  req, tag_eq, lo_override;
  logic                  buf_wr, buf_clear, buf_set, tag_load, buf_valid;
  logic [31:0]           buf_rd;
  logic [31-LINE_BITS:0] buf_tag;
  logic                  unused_bits;

  wb_sdram_port_linebuf #(.BURST_LENGTH(BURST_LENGTH), .LINE_BITS(LINE_BITS)) u_linebuf (
    .clk_i       (sdram_clk),
    .rst_ni      (sdram_rst_n),
    .wr_en_i     (buf_wr),
    .wr_idx_i    (ctrl_adr_i[LINE_BITS-1:1]),
    .wr_dat_i    (ctrl_dat_i),
    .rd_widx_i   (wb_adr_i[LINE_BITS-1:2]),
    .rd_dat_o    (buf_rd),
    .tag_load_i  (tag_load),
    .tag_i       (wb_adr_i[31:LINE_BITS]),
    .tag_o       (buf_tag),
    .clear_i     (buf_clear),
    .set_valid_i (buf_set),
    .valid_o     (buf_valid)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    we_d      = we_q;
    ack_d     = 1'b0;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    rdat_d    = rdat_q;
    cnt_d     = cnt_q;
    beat0_d   = beat0_q;
    buf_wr    = 1'b0;
    buf_clear = 1'b0;
    buf_set   = 1'b0;
    tag_load  = 1'b0;
    req       = wb_cyc_i & wb_stb_i & ~ack_q;
    tag_eq    = (wb_adr_i[31:LINE_BITS] == buf_tag);
    case (state_q)
      IDLE: if (req) begin
        if (wb_we_i) begin
          if (tag_eq) buf_clear = 1'b1;
          if (wb_sel_i[3:2] != 2'b00) begin
            state_d = WR_HI;
            acc_d = 1'b1; we_d = 1'b1;
            adr_d = {wb_adr_i[31:2], 2'b00}; dat_d = wb_dat_i[31:16]; sel_d = wb_sel_i[3:2];
          end else if (wb_sel_i[1:0] != 2'b00) begin
            state_d = WR_LO;
            acc_d = 1'b1; we_d = 1'b1;
            adr_d = {wb_adr_i[31:2], 2'b10}; dat_d = wb_dat_i[15:0]; sel_d = wb_sel_i[1:0];
          end else begin
            ack_d = 1'b1;
          end
        end else if (buf_valid && tag_eq) begin
          rdat_d = buf_rd;
          ack_d  = 1'b1;
        end else begin
          state_d = RD_REQ;
          acc_d = 1'b1; we_d = 1'b0;
          adr_d = {wb_adr_i[31:2], 2'b00}; sel_d = 2'b11;
          buf_clear = 1'b1;
          tag_load  = 1'b1;
        end
      end
      WR_HI: if (ctrl_ack_i) begin
        if (wb_sel_i[1:0] != 2'b00) begin
          state_d = WR_LO;
          adr_d = {wb_adr_i[31:2], 2'b10}; dat_d = wb_dat_i[15:0]; sel_d = wb_sel_i[1:0];
        end else begin
          state_d = IDLE; acc_d = 1'b0; we_d = 1'b0; ack_d = 1'b1;
        end
      end
      WR_LO: if (ctrl_ack_i) begin
        state_d = IDLE; acc_d = 1'b0; we_d = 1'b0; ack_d = 1'b1;
      end
      RD_REQ: if (ctrl_ack_i) begin
        state_d = RD_FILL;
        acc_d   = 1'b0;
        cnt_d   = CNT_W'(1);
        buf_wr  = 1'b1;
        beat0_d = ctrl_dat_i;
      end
      RD_FILL: begin
        // The burst wraps, so beats 0 and 1 are the requested word.
        buf_wr = 1'b1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          rdat_d = {beat0_q, ctrl_dat_i};
          ack_d  = 1'b1;
        end
        if (cnt_q == CNT_W'(BURST_LENGTH - 1)) begin
          buf_set = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) begin
      state_q <= IDLE;
      acc_q   <= 1'b0;
      we_q    <= 1'b0;
      ack_q   <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      rdat_q  <= '0;
      cnt_q   <= '0;
      beat0_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      we_q    <= we_d;
      ack_q   <= ack_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      rdat_q  <= rdat_d;
      cnt_q   <= cnt_d;
      beat0_q <= beat0_d;
    end
  end

  // The controller samples acc/adr in its ack cycle, so the next request (or
  // its absence) has to be visible combinationally in that same cycle.
  assign lo_override = (state_q == WR_HI) && ctrl_ack_i && (wb_sel_i[1:0] != 2'b00);
  assign ctrl_acc_o  = acc_q & ~(ctrl_ack_i & ((state_q == WR_LO) || (state_q == RD_REQ) ||
                                               ((state_q == WR_HI) && (wb_sel_i[1:0] == 2'b00))));
  assign ctrl_adr_o  = lo_override ? {wb_adr_i[31:2], 2'b10} : adr_q;
  assign ctrl_dat_o  = lo_override ? wb_dat_i[15:0] : dat_q;
  assign ctrl_sel_o  = lo_override ? wb_sel_i[1:0] : sel_q;
  assign ctrl_we_o   = we_q;

  assign wb_ack_o     = ack_q;
  assign wb_dat_o     = rdat_q;
  assign state_o      = state_q;
  assign line_valid_o = buf_valid;

  assign unused_bits = ^{wb_adr_i[1:0], ctrl_adr_i[31:LINE_BITS], ctrl_adr_i[0]};

endmodule

// File: tb/tb_wb_sdram_port.sv
// Directed bench for wb_sdram_port with a behavioural controller model.
module tb_wb_sdram_port;

  localparam int BL = 8;
  localparam int LB = 4;

  logic        sdram_clk = 1'b0;
  logic        sdram_rst_n;
  logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i, wb_cyc_i, wb_stb_i, wb_ack_o;
  logic        ctrl_acc_o, ctrl_we_o, ctrl_ack_i;
  logic [31:0] ctrl_adr_o, ctrl_adr_i;
  logic [15:0] ctrl_dat_o, ctrl_dat_i;
  logic [1:0]  ctrl_sel_o;
  logic [2:0]  state_o;
  logic        line_valid_o;

  wb_sdram_port #(.BURST_LENGTH(BL)) dut (
    .sdram_clk(sdram_clk), .sdram_rst_n(sdram_rst_n),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .ctrl_acc_o(ctrl_acc_o), .ctrl_adr_o(ctrl_adr_o), .ctrl_dat_o(ctrl_dat_o),
    .ctrl_sel_o(ctrl_sel_o), .ctrl_we_o(ctrl_we_o), .ctrl_ack_i(ctrl_ack_i),
    .ctrl_adr_i(ctrl_adr_i), .ctrl_dat_i(ctrl_dat_i),
    .state_o(state_o), .line_valid_o(line_valid_o)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 sdram_clk = ~sdram_clk;

  int cyc_cnt = 0;
  always @(posedge sdram_clk) cyc_cnt <= cyc_cnt + 1;

  int checks = 0;
  int errors = 0;
  int wb_ack_cnt = 0;
  int acc_cnt = 0;

  always @(negedge sdram_clk) begin
    if (wb_ack_o) wb_ack_cnt++;
    if (ctrl_acc_o) acc_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard: controller requests ----------------
  // Entry: {we, adr[31:0], dat[15:0], sel[1:0]}; reads carry dat=0, sel=0.
  logic [50:0] exp_q[$];
  logic [50:0] obs_q[$];

  task automatic exp_wr(input logic [31:0] adr, input logic [15:0] dat, input logic [1:0] sel);
    exp_q.push_back({1'b1, adr, dat, sel});
  endtask

  task automatic exp_rd(input logic [31:0] adr);
    exp_q.push_back({1'b0, adr, 16'h0, 2'b00});
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0)
      chk(tag, 64'(obs_q.pop_front()), 64'(exp_q.pop_front()));
    obs_q.delete();
    exp_q.delete();
  endtask

  // ---------------- controller model ----------------
  logic [31:0] req_adr;
  logic        req_we;
  bit          have_req;
  logic [15:0] beat_base;
  logic [2:0]  hidx;
  int          last_ack_cyc, first_ack_cyc;

  task automatic capture();
    req_we  = ctrl_we_o;
    req_adr = ctrl_adr_o;
    obs_q.push_back({ctrl_we_o, ctrl_adr_o, ctrl_we_o ? ctrl_dat_o : 16'h0,
                     ctrl_we_o ? ctrl_sel_o : 2'b00});
    have_req = 1'b1;
  endtask

  initial begin
    ctrl_ack_i = 1'b0; ctrl_adr_i = '0; ctrl_dat_i = '0;
    have_req = 1'b0; beat_base = 16'h1111;
    forever begin
      if (!have_req) begin
        @(negedge sdram_clk);
        if (sdram_rst_n && ctrl_acc_o) capture();
      end else begin
        have_req = 1'b0;
        repeat (2) @(posedge sdram_clk);
        #1;
        if (sdram_rst_n && req_we) begin
          ctrl_ack_i = 1'b1;
          last_ack_cyc = cyc_cnt;
          @(negedge sdram_clk);
          if (ctrl_acc_o) capture();
          @(posedge sdram_clk); #1;
          ctrl_ack_i = 1'b0;
        end else if (sdram_rst_n) begin
          first_ack_cyc = cyc_cnt;
          for (int b = 0; b < BL; b++) begin
            if (!sdram_rst_n) break;
            ctrl_ack_i = (b == 0);
            hidx = req_adr[LB-1:1] + 3'(b);
            ctrl_adr_i = {req_adr[31:LB], hidx, 1'b0};
            ctrl_dat_i = 16'(beat_base * 16'(b + 1));
            @(posedge sdram_clk); #1;
          end
          ctrl_ack_i = 1'b0; ctrl_adr_i = '0; ctrl_dat_i = '0;
        end
      end
    end
  end

  // ---------------- bus driver ----------------
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rdat,
                         output int lat, output int ack_cyc);
    int start;
    int n;
    @(posedge sdram_clk); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
    start = cyc_cnt;
    n = 0;
    do begin
      @(negedge sdram_clk);
      n++;
    end while (!wb_ack_o && n < 100);
    chk("wb_ack_seen", 64'(wb_ack_o), 64'd1);
    rdat = wb_dat_o;
    ack_cyc = cyc_cnt;
    lat = ack_cyc - start;
    @(posedge sdram_clk); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge sdram_clk);
    #1;
  endtask

  // ---------------- directed tests ----------------
  logic [31:0] hit_exp [4] = '{32'h33334444, 32'h55556666, 32'h77778888, 32'h11112222};

  initial begin
    logic [31:0] rd;
    int lat, ack_cyc, a0, c0;
    sdram_rst_n = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
    repeat (3) @(posedge sdram_clk);
    @(negedge sdram_clk);
    chk("rst_wb_ack", 64'(wb_ack_o), 64'd0);
    chk("rst_wb_dat", 64'(wb_dat_o), 64'd0);
    chk("rst_acc", 64'(ctrl_acc_o), 64'd0);
    chk("rst_we", 64'(ctrl_we_o), 64'd0);
    chk("rst_adr", 64'(ctrl_adr_o), 64'd0);
    chk("rst_dat", 64'(ctrl_dat_o), 64'd0);
    chk("rst_sel", 64'(ctrl_sel_o), 64'd0);
    chk("rst_valid", 64'(line_valid_o), 64'd0);
    chk("rst_state", 64'(state_o), 64'd0);
    sdram_rst_n = 1'b1;

    // Full-word write: two halfword accesses, high half first.
    a0 = wb_ack_cnt;
    wb_xfer(1'b1, 32'h100, 32'hDEADBEEF, 4'b1111, rd, lat, ack_cyc);
    chk("wr_full_ack_lat", 64'(ack_cyc - last_ack_cyc), 64'd1);
    idle(4);
    chk("wr_full_ack_cnt", 64'(wb_ack_cnt - a0), 64'd1);
    exp_wr(32'h100, 16'hDEAD, 2'b11);
    exp_wr(32'h102, 16'hBEEF, 2'b11);
    check_log("wr_full");

    wb_xfer(1'b1, 32'h100, 32'hDEADBEEF, 4'b0011, rd, lat, ack_cyc);
    chk("wr_lo_ack_lat", 64'(ack_cyc - last_ack_cyc), 64'd1);
    idle(4);
    exp_wr(32'h102, 16'hBEEF, 2'b11);
    check_log("wr_lo");

    wb_xfer(1'b1, 32'h200, 32'h12345678, 4'b1100, rd, lat, ack_cyc);
    chk("wr_hi_ack_lat", 64'(ack_cyc - last_ack_cyc), 64'd1);
    idle(4);
    exp_wr(32'h200, 16'h1234, 2'b11);
    check_log("wr_hi");

    wb_xfer(1'b1, 32'h204, 32'h0BADF00D, 4'b0100, rd, lat, ack_cyc);
    idle(4);
    exp_wr(32'h204, 16'h0BAD, 2'b01);
    check_log("wr_byte1");

    c0 = acc_cnt;
    wb_xfer(1'b1, 32'h300, 32'hFFFFFFFF, 4'b0000, rd, lat, ack_cyc);
    chk("wr_none_lat", 64'(lat), 64'd1);
    idle(4);
    chk("wr_none_acc", 64'(acc_cnt - c0), 64'd0);
    check_log("wr_none");

    // Read miss, requested word mid-line; burst wraps from halfword 6.
    beat_base = 16'h1111;
    wb_xfer(1'b0, 32'h10C, 32'h0, 4'b1111, rd, lat, ack_cyc);
    chk("miss_data", 64'(rd), 64'h11112222);
    chk("miss_lat", 64'(ack_cyc - first_ack_cyc), 64'd2);
    idle(10);
    chk("miss_valid", 64'(line_valid_o), 64'd1);
    exp_rd(32'h10C);
    check_log("miss");

    // Hits over the whole line verify the wrapped placement of all beats.
    c0 = acc_cnt;
    for (int i = 0; i < 4; i++) begin
      wb_xfer(1'b0, 32'h100 + 32'(4 * i), 32'h0, 4'b1111, rd, lat, ack_cyc);
      chk($sformatf("hit_data_%0d", i), 64'(rd), 64'(hit_exp[i]));
      chk($sformatf("hit_lat_%0d", i), 64'(lat), 64'd1);
    end
    chk("hit_no_acc", 64'(acc_cnt - c0), 64'd0);
    check_log("hit");

    // A write into the buffered line invalidates it.
    wb_xfer(1'b1, 32'h104, 32'hCAFEF00D, 4'b1111, rd, lat, ack_cyc);
    idle(4);
    chk("wr_inval_valid", 64'(line_valid_o), 64'd0);
    beat_base = 16'h0101;
    wb_xfer(1'b0, 32'h100, 32'h0, 4'b1111, rd, lat, ack_cyc);
    chk("remiss_data", 64'(rd), 64'h01010202);
    idle(10);
    exp_wr(32'h104, 16'hCAFE, 2'b11);
    exp_wr(32'h106, 16'hF00D, 2'b11);
    exp_rd(32'h100);
    check_log("remiss");

    // Reset in the middle of a fill.
    beat_base = 16'h0A0A;
    wb_xfer(1'b0, 32'h200, 32'h0, 4'b1111, rd, lat, ack_cyc);
    chk("fill_data", 64'(rd), 64'h0A0A1414);
    @(negedge sdram_clk);
    chk("fill_state", 64'(state_o), 64'd4);
    sdram_rst_n = 1'b0;
    #1;
    chk("mrst_wb_ack", 64'(wb_ack_o), 64'd0);
    chk("mrst_wb_dat", 64'(wb_dat_o), 64'd0);
    chk("mrst_acc", 64'(ctrl_acc_o), 64'd0);
    chk("mrst_we", 64'(ctrl_we_o), 64'd0);
    chk("mrst_adr", 64'(ctrl_adr_o), 64'd0);
    chk("mrst_dat", 64'(ctrl_dat_o), 64'd0);
    chk("mrst_sel", 64'(ctrl_sel_o), 64'd0);
    chk("mrst_valid", 64'(line_valid_o), 64'd0);
    chk("mrst_state", 64'(state_o), 64'd0);
    repeat (2) @(negedge sdram_clk);
    sdram_rst_n = 1'b1;
    idle(4);
    exp_rd(32'h200);
    check_log("pre_rst");

    // After reset the line is gone: the same read misses again.
    wb_xfer(1'b0, 32'h208, 32'h0, 4'b1111, rd, lat, ack_cyc);
    chk("post_rst_data", 64'(rd), 64'h0A0A1414);
    idle(10);
    exp_rd(32'h208);
    check_log("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
